// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, PC hold/redirect control, decode handshake.
// Optional WAIT timeout with fetch_err pulse is enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        hold,
  output logic        pc_sel,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PEND} state_t;

  state_t state_q, state_d;
  logic   squash_q, squash_d;
  logic   cap_pc, cap_instr;
  logic   timeout;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q;

  // The last WAIT cycle that may still see a response is TIMEOUT_CYCLES-1 after entry.
  assign timeout = (state_q == S_WAIT) && !imem_rvalid &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      fetch_err  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT && state_d == S_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
      fetch_err  <= timeout;
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Fetched-instruction buffer: address at grant, data at an unsquashed response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      if (cap_pc)    if_pc    <= pc_in;
      if (cap_instr) if_instr <= imem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    squash_d  = squash_q;
    cap_pc    = 1'b0;
    cap_instr = 1'b0;
    hold      = 1'b1;
    pc_sel    = redirect_valid;
    next_pc   = redirect_pc;
    imem_req  = 1'b0;
    imem_addr = pc_in;
    if_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        // A redirect retires this address; the PC reloads before the next issue.
        if (!redirect_valid && imem_gnt) begin
          state_d  = S_WAIT;
          cap_pc   = 1'b1;
          squash_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          squash_d = 1'b0;
          if (squash_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_PEND;
            cap_instr = 1'b1;
          end
        end else if (timeout) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      S_PEND: begin
        if_valid = 1'b1;
        if (redirect_valid || if_ready) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid || (state_q == S_PEND && if_ready)) hold = 1'b0;
    if (!rst_n) hold = 1'b1;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a flag-based model.
module tb_fetch_ctrl;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        hold, pc_sel;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        fetch_err;

  fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .hold(hold), .pc_sel(pc_sel), .next_pc(next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: started = past the post-reset idle cycle, issued = request granted and
  // awaiting data, buffered = instruction held for decode.
  bit          m_started, m_issued, m_buf, m_squash, m_err;
  int          m_wait;
  logic [31:0] m_pc, m_if_pc, m_if_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] start_pc);
    m_started = 0; m_issued = 0; m_buf = 0; m_squash = 0; m_err = 0; m_wait = 0;
    m_pc = start_pc; m_if_pc = '0; m_if_instr = '0;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; if_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    model_reset(start_pc);
    pc_in = m_pc;
    #1;
    chk("rst_hold", 32'(hold), 32'd1);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive inputs, compare every output with the model, then advance the model.
  task automatic cycle(input bit gnt, input bit rv, input logic [31:0] rdata,
                       input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          e_req, hs, e_hold;
    logic [31:0] cur_pc;
    @(negedge clk);
    cur_pc = m_pc;
    pc_in = cur_pc; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
    if_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    #1;
    e_req  = m_started && !m_issued && !m_buf;
    hs     = m_buf && rdy;
    e_hold = !(redir || hs);
    chk("hold", 32'(hold), 32'(e_hold));
    chk("pc_sel", 32'(pc_sel), 32'(redir));
    chk("next_pc", next_pc, rpc);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, cur_pc);
    chk("if_valid", 32'(if_valid), 32'(m_buf));
    if (m_buf) begin
      chk("if_instr", if_instr, m_if_instr);
      chk("if_pc", if_pc, m_if_pc);
    end
    chk("fetch_err", 32'(fetch_err), 32'(m_err));

    if (!e_hold) m_pc = redir ? rpc : cur_pc + 32'd4;
    m_err = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (e_req) begin
      if (!redir && gnt) begin
        m_issued = 1; m_if_pc = cur_pc; m_squash = 0; m_wait = 0;
      end
    end else if (m_issued) begin
      if (rv) begin
        m_issued = 0;
        if (!(m_squash || redir)) begin
          m_buf = 1; m_if_instr = rdata;
        end
        m_squash = 0; m_wait = 0;
      end else begin
        m_wait++;
        if (redir) m_squash = 1;
`ifdef FETCH_CTRL_TIMEOUT_EN
        if (m_wait == TO) begin
          m_issued = 0; m_err = 1; m_squash = 0; m_wait = 0;
        end
`endif
      end
    end else if (m_buf) begin
      if (redir || hs) m_buf = 0;
    end
  endtask

  task automatic rand_cycle();
    cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), $urandom,
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
  endtask

  initial begin
    do_reset(32'h0);

    // Zero-wait memory: REQ at cycle 1, instruction at cycle 3.
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("c1_imem_req", 32'(imem_req), 32'd1);
    chk("c1_imem_addr", imem_addr, 32'h0);
    cycle(0, 1, 32'h0000_0013, 1, 0, 0);
    chk("c2_hold", 32'(hold), 32'd1);
    cycle(0, 0, 0, 1, 0, 0);
    chk("c3_if_valid", 32'(if_valid), 32'd1);
    chk("c3_if_pc", if_pc, 32'h0);
    chk("c3_if_instr", if_instr, 32'h0000_0013);
    chk("c3_hold", 32'(hold), 32'd0);

    // Decode stalls five cycles in PEND.
    cycle(1, 0, 0, 0, 0, 0);
    chk("stall_addr", imem_addr, 32'h4);
    cycle(0, 1, 32'hCAFE_0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("stall_hold", 32'(hold), 32'd1);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_if_instr", if_instr, 32'hCAFE_0001);
    end
    cycle(0, 0, 0, 1, 0, 0);
    chk("stall_adv_hold", 32'(hold), 32'd0);
    chk("stall_adv_pc_sel", 32'(pc_sel), 32'd0);

    // Redirect while waiting: response dropped, next fetch at 0x100.
    cycle(1, 0, 0, 1, 0, 0);
    chk("w_addr", imem_addr, 32'h8);
    cycle(0, 0, 0, 1, 1, 32'h100);
    chk("w_redir_pc_sel", 32'(pc_sel), 32'd1);
    chk("w_redir_hold", 32'(hold), 32'd0);
    cycle(0, 1, 32'hBAD0_BAD0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("w_redir_addr", imem_addr, 32'h100);
    chk("w_redir_if_valid", 32'(if_valid), 32'd0);

    // Redirect on the PEND handshake cycle: no PC+4 step.
    cycle(0, 1, 32'h0000_0033, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h200);
    chk("p_redir_pc_sel", 32'(pc_sel), 32'd1);
    chk("p_redir_hold", 32'(hold), 32'd0);
    chk("p_redir_if_pc", if_pc, 32'h100);
    cycle(0, 0, 0, 1, 0, 0);
    chk("p_redir_addr", imem_addr, 32'h200);
    chk("p_redir_if_valid", 32'(if_valid), 32'd0);

`ifdef FETCH_CTRL_TIMEOUT_EN
    // Withheld response: error pulse after TO WAIT cycles, same address re-requested.
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < int'(TO); i++) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'hDEAD_0000, 1, 0, 0);
    chk("to_fetch_err", 32'(fetch_err), 32'd1);
    chk("to_imem_req", 32'(imem_req), 32'd1);
    chk("to_imem_addr", imem_addr, 32'h200);
    cycle(0, 0, 0, 1, 0, 0);
    chk("to_err_clear", 32'(fetch_err), 32'd0);
    chk("to_late_ignored", 32'(if_valid), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) rand_cycle();

    // Reset mid-traffic; stale responses after release must not produce instructions.
    do_reset($urandom & 32'hFFFF_FFFC);
    cycle(0, 1, 32'h1111_1111, 1, 0, 0);
    cycle(0, 1, 32'h2222_2222, 1, 0, 0);
    chk("post_rst_no_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 1000; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max WAIT cycles before re-issue (used only with FETCH_CTRL_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_in  input  32  current PC value from the program counter.
REQ-005 hold  output  1  to PC: 1 = freeze PC.
REQ-006 pc_sel  output  1  to PC: 1 = load next_pc, 0 = PC+4.
REQ-007 next_pc  output  32  to PC: redirect target.
REQ-008 redirect_valid  input  1  single-cycle branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target, valid with redirect_valid.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  request address.
REQ-012 imem_gnt  input  1  request accepted this cycle.
REQ-013 imem_rvalid  input  1  response data valid.
REQ-014 imem_rdata  input  32  response instruction.
REQ-015 if_valid  output  1  fetched instruction available to decode.
REQ-016 if_ready  input  1  decode accepts instruction.
REQ-017 if_instr  output  32  fetched instruction.
REQ-018 if_pc  output  32  address of if_instr.
REQ-019 fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, PEND; exactly one outstanding memory request.
REQ-021 IDLE: entered on reset; unconditional transition to REQ next cycle.
REQ-022 REQ: imem_req=1, imem_addr=pc_in; imem_gnt -> WAIT, address captured into if_pc register; no gnt -> stay REQ, address may change (no stability rule before gnt).
REQ-023 WAIT: imem_rvalid -> if_instr<=imem_rdata, PEND; imem_rvalid outside WAIT ignored.
REQ-024 PEND: if_valid=1, if_instr/if_pc stable until if_valid&&if_ready; on handshake -> REQ.
REQ-025 Advance: hold=0, pc_sel=0 exactly in the handshake cycle; all other cycles hold=1 unless REQ-026 applies.
REQ-026 Redirect (any state): hold=0, pc_sel=1, next_pc=redirect_pc combinationally in the redirect_valid cycle; redirect has priority over advance.
REQ-027 Redirect in REQ or IDLE: next state REQ (new pc_in issued after PC loads).
REQ-028 Redirect in PEND: buffered instruction discarded, if_valid=0 next cycle, -> REQ; simultaneous handshake still counts as consumed.
REQ-029 Redirect in WAIT: squash flag set, stay WAIT; returning response discarded (no PEND), -> REQ, squash cleared; redirect coincident with rvalid discards that response.
REQ-030 Zero-wait memory (gnt with req, rvalid next cycle, if_ready=1): one instruction per 3 cycles (REQ, WAIT, PEND).
REQ-031 next_pc = redirect_pc at all times (pass-through); pc_sel = redirect_valid.

Reset
REQ-032 rst_n low: state IDLE, hold=1, imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, squash=0, timeout counter=0.
REQ-033 Reset mid-request: outstanding transaction abandoned; responses arriving after reset release are ignored until the first new grant.

Configuration
REQ-034 Macro FETCH_CTRL_TIMEOUT_EN defined: counter counts WAIT cycles; reaching TIMEOUT_CYCLES without rvalid -> fetch_err=1 one cycle, squash cleared, -> REQ re-issuing current pc_in; counter cleared on leaving WAIT.
REQ-035 FETCH_CTRL_TIMEOUT_EN undefined: no counter logic, fetch_err tied 0, WAIT held indefinitely.

Verification
REQ-036 Reset release, pc_in=0, zero-wait memory returning 0x00000013, if_ready=1 -> imem_addr=0 in cycle 1, if_valid with if_pc=0 in cycle 3, hold=0 that cycle only.
REQ-037 if_ready=0 for 5 cycles in PEND -> if_valid/if_instr/if_pc stable, hold=1 throughout, single advance on handshake.
REQ-038 redirect_valid with redirect_pc=0x100 in WAIT -> pending response discarded, if_valid stays 0, next imem_addr=0x100.
REQ-039 Redirect coincident with PEND handshake, redirect_pc=0x200 -> pc_sel=1, hold=0, next request at 0x200, no PC+4 step.
REQ-040 FETCH_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid withheld -> fetch_err pulse after 16 WAIT cycles, re-request same address; late rvalid in REQ ignored.
